// File: rtl/fiber_req_arbiter_if.sv
// Purpose : PE-side and bank-side request/response bundle for fiber_req_arbiter.
// Latency : wires only; no state.
// Backpressure: carries valid/ready pairs on both sides. The slave modport is
//   the arbiter's view (i_* in, o_* out). The master modport is the view of
//   the surrounding PEs and bank.
// Ports   : pe request (type/addr/data/valid/ready), pe response (data/valid/ready),
//           bank request (type/addr/data/valid/ready), bank response (data/valid/ready).
interface fiber_req_arbiter_if #(
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 64
);
  logic [NUM_PE*4-1:0]          i_pe_request_type;
  logic [NUM_PE*ADDR_WIDTH-1:0] i_pe_addr;
  logic [NUM_PE*DATA_WIDTH-1:0] i_pe_data;
  logic [NUM_PE-1:0]            i_pe_type_valid;
  logic [NUM_PE-1:0]            o_pe_type_ready;
  logic [DATA_WIDTH-1:0]        o_pe_data_o;
  logic [NUM_PE-1:0]            o_pe_data_o_valid;
  logic [NUM_PE-1:0]            i_pe_data_o_ready;
  logic [3:0]                   o_bank_request_type;
  logic [ADDR_WIDTH-1:0]        o_bank_addr;
  logic [DATA_WIDTH-1:0]        o_bank_data;
  logic                         o_bank_type_valid;
  logic                         i_bank_type_ready;
  logic [DATA_WIDTH-1:0]        i_bank_data_o;
  logic                         i_bank_data_o_valid;
  logic                         o_bank_data_o_ready;

  modport slave (
    input  i_pe_request_type, i_pe_addr, i_pe_data, i_pe_type_valid, i_pe_data_o_ready,
    input  i_bank_type_ready, i_bank_data_o, i_bank_data_o_valid,
    output o_pe_type_ready, o_pe_data_o, o_pe_data_o_valid,
    output o_bank_request_type, o_bank_addr, o_bank_data, o_bank_type_valid,
    output o_bank_data_o_ready
  );

  modport master (
    output i_pe_request_type, i_pe_addr, i_pe_data, i_pe_type_valid, i_pe_data_o_ready,
    output i_bank_type_ready, i_bank_data_o, i_bank_data_o_valid,
    input  o_pe_type_ready, o_pe_data_o, o_pe_data_o_valid,
    input  o_bank_request_type, o_bank_addr, o_bank_data, o_bank_type_valid,
    input  o_bank_data_o_ready
  );
endinterface

// File: rtl/fiber_req_arbiter.sv
// Purpose : round-robin arbiter funnelling NUM_PE requesters into one fiberBank port.
// Latency : grant is combinational in IDLE. The bank request is valid the cycle after
//           accept. A response passes straight through from bank to PE in WAIT_RESP.
// Backpressure: only one transaction is in flight at a time. PE ready is low outside IDLE.
//           The bank request is held until i_bank_type_ready. The bank response is
//           held off by the owning PE's i_pe_data_o_ready.
// Ports   : i_clk, i_reset (sync, active-high); pe_if (slave modport) carries all PE/bank
//           handshakes; o_busy (state != IDLE), o_err (bad type pulse), o_timeout (pulse).
// Config  : define FIBER_ARB_TIMEOUT_EN to abandon WAIT_RESP after TIMEOUT_CYCLES cycles.
//           When it is undefined, the arbiter waits indefinitely and o_timeout is 0.
module fiber_req_arbiter #(
  parameter int NUM_PE         = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               i_clk,
  input  logic               i_reset,
  fiber_req_arbiter_if.slave pe_if,
  output logic               o_busy,
  output logic               o_err,
  output logic               o_timeout
);
  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [3:0] T_READ    = 4'b0010;
  localparam logic [3:0] T_CONSUME = 4'b1000;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t                  state_q;
  logic [PTR_W-1:0]        rr_ptr_q;
  logic [PTR_W-1:0]        grant_q;
  logic [3:0]              type_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    err_q;

  // Round-robin search starts one past the last grant.
  logic                    gnt_vld;
  logic [PTR_W-1:0]        gnt_idx;
  logic [PTR_W-1:0]        cand;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_PE; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_PE);
      if (!gnt_vld && pe_if.i_pe_type_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  logic       accept;
  logic [3:0] gnt_type;
  logic       type_ok;
  logic       rsp_hs;
  assign accept   = (state_q == IDLE) && gnt_vld;
  assign gnt_type = pe_if.i_pe_request_type[int'(gnt_idx)*4 +: 4];
  assign type_ok  = (gnt_type != 4'b0000) && ((gnt_type & (gnt_type - 4'd1)) == 4'b0000);
  assign rsp_hs   = (state_q == WAIT_RESP) && pe_if.i_bank_data_o_valid
                    && pe_if.i_pe_data_o_ready[grant_q];

  always_comb begin
    pe_if.o_pe_type_ready = '0;
    if (accept) pe_if.o_pe_type_ready[gnt_idx] = 1'b1;
  end

  // Response path is a pure pass-through steered to the owning PE.
  always_comb begin
    pe_if.o_pe_data_o         = '0;
    pe_if.o_pe_data_o_valid   = '0;
    pe_if.o_bank_data_o_ready = 1'b0;
    if (state_q == WAIT_RESP) begin
      pe_if.o_pe_data_o                = pe_if.i_bank_data_o;
      pe_if.o_pe_data_o_valid[grant_q] = pe_if.i_bank_data_o_valid;
      pe_if.o_bank_data_o_ready        = pe_if.i_pe_data_o_ready[grant_q];
    end
  end

  assign pe_if.o_bank_request_type = type_q;
  assign pe_if.o_bank_addr         = addr_q;
  assign pe_if.o_bank_data         = data_q;
  assign pe_if.o_bank_type_valid   = (state_q == ISSUE);
  assign o_busy                    = (state_q != IDLE);
  assign o_err                     = err_q;

`ifdef FIBER_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q;
  logic             timeout_q;
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= PTR_W'(NUM_PE - 1);
      grant_q  <= '0;
      type_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
`ifdef FIBER_ARB_TIMEOUT_EN
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
`ifdef FIBER_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            type_q   <= gnt_type;
            addr_q   <= pe_if.i_pe_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            data_q   <= pe_if.i_pe_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            grant_q  <= gnt_idx;
            rr_ptr_q <= gnt_idx;
            // A malformed type is consumed but never reaches the bank.
            if (type_ok) state_q <= ISSUE;
            else         err_q   <= 1'b1;
          end
        end
        ISSUE: begin
          if (pe_if.i_bank_type_ready) begin
            if (type_q == T_READ || type_q == T_CONSUME) begin
              state_q <= WAIT_RESP;
`ifdef FIBER_ARB_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WAIT_RESP: begin
          if (rsp_hs) begin
            state_q <= IDLE;
          end
`ifdef FIBER_ARB_TIMEOUT_EN
          else if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fiber_req_arbiter.sv
// Purpose : directed self-checking bench for fiber_req_arbiter.
// Latency : inputs are driven just after the falling edge and checked 1 time unit later.
// Backpressure: the bench plays PEs and bank, toggling ready/valid directly.
// Ports   : drives the master modport side of fiber_req_arbiter_if. Honours FIBER_ARB_TIMEOUT_EN.
module tb_fiber_req_arbiter;
  localparam int NPE = 4;
  localparam int DW  = 16;
  localparam int AW  = 64;
`ifdef FIBER_ARB_TIMEOUT_EN
  localparam int TO  = 8;
`else
  localparam int TO  = 255;
`endif
  localparam logic [3:0] FETCH = 4'b0001, READ = 4'b0010, WRITE = 4'b0100, CONSUME = 4'b1000;

  logic clk = 1'b0;
  logic rst;
  logic busy, err, tmo;
  int   checks = 0;
  int   errors = 0;

  fiber_req_arbiter_if #(.NUM_PE(NPE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fiber_req_arbiter #(.NUM_PE(NPE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(rst), .pe_if(bus), .o_busy(busy), .o_err(err), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.i_pe_request_type   = '0;
    bus.i_pe_addr           = '0;
    bus.i_pe_data           = '0;
    bus.i_pe_type_valid     = '0;
    bus.i_pe_data_o_ready   = '0;
    bus.i_bank_type_ready   = 1'b0;
    bus.i_bank_data_o       = '0;
    bus.i_bank_data_o_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int pe, input logic [3:0] t, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.i_pe_request_type[pe*4 +: 4] = t;
    bus.i_pe_addr[pe*AW +: AW]       = a;
    bus.i_pe_data[pe*DW +: DW]       = d;
    bus.i_pe_type_valid[pe]          = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b exp=0", tmo); end
    checks++; if (bus.o_bank_type_valid !== 1'b0) begin errors++; $display("FAIL rst_bank_vld got=%b exp=0", bus.o_bank_type_valid); end
    checks++; if (bus.o_bank_addr !== 64'h0) begin errors++; $display("FAIL rst_bank_addr got=%h exp=0", bus.o_bank_addr); end
    checks++; if (bus.o_pe_data_o_valid !== 4'b0000) begin errors++; $display("FAIL rst_rsp_vld got=%b exp=0000", bus.o_pe_data_o_valid); end
    checks++; if (bus.o_bank_data_o_ready !== 1'b0) begin errors++; $display("FAIL rst_bank_rdy got=%b exp=0", bus.o_bank_data_o_ready); end
    checks++; if (bus.o_pe_type_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready_idle got=%b exp=0000", bus.o_pe_type_ready); end
    set_req(1, FETCH, 64'h10, 16'h0);
    #1;
    checks++; if (bus.o_pe_type_ready !== 4'b0010) begin errors++; $display("FAIL rst_ready_pe1 got=%b exp=0010", bus.o_pe_type_ready); end
    clear_inputs();
  endtask

  task automatic test_write_pair();
    do_reset();
    set_req(0, WRITE, 64'h00000000FFFFFFFF, 16'hFFFF);
    set_req(2, WRITE, 64'h00000000FFFFFFFF, 16'hFFFF);
    bus.i_bank_type_ready = 1'b1;
    #1;
    checks++; if (bus.o_pe_type_ready !== 4'b0001) begin errors++; $display("FAIL wr_grant0 got=%b exp=0001", bus.o_pe_type_ready); end
    @(negedge clk);
    bus.i_pe_type_valid[0] = 1'b0;
    #1;
    checks++; if (bus.o_bank_type_valid !== 1'b1) begin errors++; $display("FAIL wr_bank_vld1 got=%b exp=1", bus.o_bank_type_valid); end
    checks++; if (bus.o_pe_type_ready !== 4'b0000) begin errors++; $display("FAIL wr_ready_issue got=%b exp=0000", bus.o_pe_type_ready); end
    checks++; if (bus.o_bank_request_type !== WRITE) begin errors++; $display("FAIL wr_type got=%b exp=0100", bus.o_bank_request_type); end
    checks++; if (bus.o_bank_addr !== 64'h00000000FFFFFFFF) begin errors++; $display("FAIL wr_addr got=%h exp=00000000ffffffff", bus.o_bank_addr); end
    checks++; if (bus.o_bank_data !== 16'hFFFF) begin errors++; $display("FAIL wr_data got=%h exp=ffff", bus.o_bank_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got=%b exp=1", busy); end
    @(negedge clk);
    #1;
    checks++; if (bus.o_bank_type_valid !== 1'b0) begin errors++; $display("FAIL wr_bank_gap got=%b exp=0", bus.o_bank_type_valid); end
    checks++; if (bus.o_pe_type_ready !== 4'b0100) begin errors++; $display("FAIL wr_grant2 got=%b exp=0100", bus.o_pe_type_ready); end
    @(negedge clk);
    bus.i_pe_type_valid = '0;
    #1;
    checks++; if (bus.o_bank_type_valid !== 1'b1) begin errors++; $display("FAIL wr_bank_vld2 got=%b exp=1", bus.o_bank_type_valid); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle got=%b exp=0", busy); end
    clear_inputs();
  endtask

  task automatic test_read_rr();
    logic [3:0] exp;
    do_reset();
    for (int p = 0; p < NPE; p++) set_req(p, READ, 64'(p), 16'h0);
    bus.i_bank_type_ready = 1'b1;
    bus.i_pe_data_o_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'(1 << (k % NPE));
      #1;
      checks++; if (bus.o_pe_type_ready !== exp) begin errors++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, bus.o_pe_type_ready, exp); end
      @(negedge clk);
      #1;
      checks++; if (bus.o_bank_addr !== 64'(k % NPE)) begin errors++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, bus.o_bank_addr, 64'(k % NPE)); end
      checks++; if (bus.o_pe_type_ready !== 4'b0000) begin errors++; $display("FAIL rr_ready_busy k=%0d got=%b exp=0000", k, bus.o_pe_type_ready); end
      @(negedge clk);
      bus.i_bank_data_o       = 16'(k % NPE);
      bus.i_bank_data_o_valid = 1'b1;
      #1;
      checks++; if (bus.o_pe_data_o_valid !== exp) begin errors++; $display("FAIL rr_rsp_vld k=%0d got=%b exp=%b", k, bus.o_pe_data_o_valid, exp); end
      checks++; if (bus.o_pe_data_o !== 16'(k % NPE)) begin errors++; $display("FAIL rr_rsp_data k=%0d got=%h exp=%h", k, bus.o_pe_data_o, 16'(k % NPE)); end
      @(negedge clk);
      bus.i_bank_data_o_valid = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_consume_stall();
    do_reset();
    set_req(1, CONSUME, 64'h1234, 16'h0);
    bus.i_bank_type_ready = 1'b1;
    #1;
    checks++; if (bus.o_pe_type_ready !== 4'b0010) begin errors++; $display("FAIL cs_grant got=%b exp=0010", bus.o_pe_type_ready); end
    @(negedge clk);
    bus.i_pe_type_valid = '0;
    #1;
    checks++; if (bus.o_bank_request_type !== CONSUME) begin errors++; $display("FAIL cs_type got=%b exp=1000", bus.o_bank_request_type); end
    @(negedge clk);
    bus.i_bank_data_o       = 16'hABCD;
    bus.i_bank_data_o_valid = 1'b1;
    bus.i_pe_data_o_ready   = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.o_bank_data_o_ready !== 1'b0) begin errors++; $display("FAIL cs_stall_rdy c=%0d got=%b exp=0", c, bus.o_bank_data_o_ready); end
      checks++; if (bus.o_pe_data_o_valid !== 4'b0010) begin errors++; $display("FAIL cs_stall_vld c=%0d got=%b exp=0010", c, bus.o_pe_data_o_valid); end
      checks++; if (bus.o_pe_data_o !== 16'hABCD) begin errors++; $display("FAIL cs_stall_data c=%0d got=%h exp=abcd", c, bus.o_pe_data_o); end
      @(negedge clk);
    end
    bus.i_pe_data_o_ready = 4'b1111;
    #1;
    checks++; if (bus.o_bank_data_o_ready !== 1'b1) begin errors++; $display("FAIL cs_hs_rdy got=%b exp=1", bus.o_bank_data_o_ready); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cs_idle got=%b exp=0", busy); end
    checks++; if (bus.o_bank_data_o_ready !== 1'b0) begin errors++; $display("FAIL cs_ignore_rdy got=%b exp=0", bus.o_bank_data_o_ready); end
    checks++; if (bus.o_pe_data_o_valid !== 4'b0000) begin errors++; $display("FAIL cs_ignore_vld got=%b exp=0000", bus.o_pe_data_o_valid); end
    clear_inputs();
  endtask

  task automatic test_bad_type();
    do_reset();
    set_req(3, 4'b0110, 64'h33, 16'h3);
    bus.i_bank_type_ready = 1'b1;
    #1;
    checks++; if (bus.o_pe_type_ready !== 4'b1000) begin errors++; $display("FAIL bad_grant got=%b exp=1000", bus.o_pe_type_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_early got=%b exp=0", err); end
    @(negedge clk);
    bus.i_pe_type_valid = '0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err_pulse got=%b exp=1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy got=%b exp=0", busy); end
    checks++; if (bus.o_bank_type_valid !== 1'b0) begin errors++; $display("FAIL bad_bank_vld got=%b exp=0", bus.o_bank_type_valid); end
    @(negedge clk);
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_once got=%b exp=0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy2 got=%b exp=0", busy); end
    checks++; if (bus.o_bank_type_valid !== 1'b0) begin errors++; $display("FAIL bad_bank_vld2 got=%b exp=0", bus.o_bank_type_valid); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(0, READ, 64'hA0, 16'h0);
    bus.i_bank_type_ready = 1'b1;
    #1;
    checks++; if (bus.o_pe_type_ready !== 4'b0001) begin errors++; $display("FAIL to_grant got=%b exp=0001", bus.o_pe_type_ready); end
    @(negedge clk);
    bus.i_pe_type_valid = '0;
    @(negedge clk);
`ifdef FIBER_ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (busy !== 1'b1 || tmo !== 1'b0) begin errors++; $display("FAIL to_wait c=%0d busy=%b tmo=%b exp busy=1 tmo=0", c, busy, tmo); end
      @(negedge clk);
    end
    #1;
    checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", tmo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got=%b exp=0", busy); end
    @(negedge clk);
    #1;
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL to_once got=%b exp=0", tmo); end
`else
    repeat (300) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_wait_forever got=%b exp=1", busy); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL to_tied got=%b exp=0", tmo); end
`endif
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(2, READ, 64'h2, 16'h0);
    bus.i_bank_type_ready = 1'b1;
    #1;
    checks++; if (bus.o_pe_type_ready !== 4'b0100) begin errors++; $display("FAIL rm_grant got=%b exp=0100", bus.o_pe_type_ready); end
    @(negedge clk);
    bus.i_pe_type_valid = '0;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy got=%b exp=1", busy); end
    bus.i_bank_data_o       = 16'h5555;
    bus.i_bank_data_o_valid = 1'b1;
    bus.i_pe_data_o_ready   = 4'b1111;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < NPE; p++) set_req(p, READ, 64'(p), 16'h0);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle got=%b exp=0", busy); end
    checks++; if (bus.o_pe_data_o_valid !== 4'b0000) begin errors++; $display("FAIL rm_rsp_vld got=%b exp=0000", bus.o_pe_data_o_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rm_err got=%b exp=0", err); end
    checks++; if (bus.o_pe_type_ready !== 4'b0001) begin errors++; $display("FAIL rm_next_grant got=%b exp=0001", bus.o_pe_type_ready); end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_write_pair();
    test_read_rr();
    test_consume_stall();
    test_bad_type();
    test_timeout();
    test_reset_mid();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
